rename_regfile: RTL and testbench

//  Architectural register file with register renaming for the Tomasulo core. It generalises
//  the fixed 8x16 busy/value/rob_entry register file. Each register holds a value, a busy bit
//  and the ROB tag of its newest in-flight producer. Issue control renames destinations and

---
 rtl/rename_regfile_pkg.sv | 34 +++
 rtl/rename_regfile_if.sv | 44 ++++
 rtl/rename_regfile_entry.sv | 67 ++++++
 rtl/rename_regfile.sv | 93 +++++++++
 tb/tb_rename_regfile.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_regfile_pkg.sv
// rename_regfile_pkg
//   Shared types and default sizes for the renaming register file.
//   REG_DATA_W / ROB_TAG_W / NUM_ARCH_REGS / NUM_RD_PORTS : default configuration
//   regfile_t    : one register as seen by issue control {busy, rob_entry, data}
//   idx_width    : register index width, never narrower than one bit
//   pack_regfile : repacks one read port's fields into a regfile_t
package rename_regfile_pkg;

   localparam int unsigned REG_DATA_W    = 16;
   localparam int unsigned ROB_TAG_W     = 3;
   localparam int unsigned NUM_ARCH_REGS = 8;
   localparam int unsigned NUM_RD_PORTS  = 3;

   typedef struct packed {
      logic                  busy;
      logic [ROB_TAG_W-1:0]  rob_entry;
      logic [REG_DATA_W-1:0] data;
   } regfile_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic regfile_t pack_regfile(input logic                  busy,
                                             input logic [ROB_TAG_W-1:0]  tag,
                                             input logic [REG_DATA_W-1:0] data);
      regfile_t r;
      r.busy      = busy;
      r.rob_entry = tag;
      r.data      = data;
      return r;
   endfunction

endpackage

// File: rtl/rename_regfile_if.sv
// rename_regfile_if
//   Issue-side read ports, rename request, ROB commit and flush of the register file.
//   master : issue control / ROB side (drives indices, issue, commit, flush)
//   slave  : register file side (drives rd_value, rd_busy, rd_tag)
//   Read ports are packed with port 0 in the LSBs.
interface rename_regfile_if
   import rename_regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = REG_DATA_W,
   parameter int unsigned TAG_WIDTH  = ROB_TAG_W,
   parameter int unsigned NUM_REGS   = NUM_ARCH_REGS,
   parameter int unsigned NUM_RD     = NUM_RD_PORTS
);
   localparam int unsigned IDX_W = idx_width(NUM_REGS);

   logic [NUM_RD*IDX_W-1:0]      rd_idx;
   logic [NUM_RD*DATA_WIDTH-1:0] rd_value;
   logic [NUM_RD-1:0]            rd_busy;
   logic [NUM_RD*TAG_WIDTH-1:0]  rd_tag;

   logic                         iss_valid;
   logic [IDX_W-1:0]             iss_idx;
   logic [TAG_WIDTH-1:0]         iss_tag;

   logic                         cmt_valid;
   logic [IDX_W-1:0]             cmt_idx;
   logic [TAG_WIDTH-1:0]         cmt_tag;
   logic [DATA_WIDTH-1:0]        cmt_value;

   logic                         flush;

   modport master (
      output rd_idx, iss_valid, iss_idx, iss_tag,
      output cmt_valid, cmt_idx, cmt_tag, cmt_value, flush,
      input  rd_value, rd_busy, rd_tag
   );

   modport slave (
      input  rd_idx, iss_valid, iss_idx, iss_tag,
      input  cmt_valid, cmt_idx, cmt_tag, cmt_value, flush,
      output rd_value, rd_busy, rd_tag
   );

endinterface

// File: rtl/rename_regfile_entry.sv
// rename_regfile_entry
//   One architectural register: value, busy bit and ROB tag of its newest producer.
//   clk, reset : clock, synchronous active-high reset
//   iss_hit    : rename of this register this cycle, iss_tag is the new producer
//   cmt_hit    : commit to this register this cycle with cmt_tag / cmt_value
//   flush      : squash all in-flight work
//   value, busy, tag : current registered state
module rename_regfile_entry #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned TAG_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  iss_hit,
   input  logic [TAG_WIDTH-1:0]  iss_tag,
   input  logic                  cmt_hit,
   input  logic [TAG_WIDTH-1:0]  cmt_tag,
   input  logic [DATA_WIDTH-1:0] cmt_value,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] value,
   output logic                  busy,
   output logic [TAG_WIDTH-1:0]  tag
);

   logic [DATA_WIDTH-1:0] value_q, value_d;
   logic                  busy_q, busy_d;
   logic [TAG_WIDTH-1:0]  tag_q, tag_d;

   always_comb begin
      value_d = value_q;
      busy_d  = busy_q;
      tag_d   = tag_q;

      // The committing instruction is older than any squash, so its value always lands.
      if (cmt_hit) begin
         value_d = cmt_value;
      end

      if (flush) begin
         // Tags are left stale; nothing reads them while busy is clear.
         busy_d = 1'b0;
      end else if (iss_hit) begin
         busy_d = 1'b1;
         tag_d  = iss_tag;
      end else if (cmt_hit && (tag_q == cmt_tag)) begin
         // Only the newest producer may release the register.
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= '0;
         busy_q  <= 1'b0;
         tag_q   <= '0;
      end else begin
         value_q <= value_d;
         busy_q  <= busy_d;
         tag_q   <= tag_d;
      end
   end

   assign value = value_q;
   assign busy  = busy_q;
   assign tag   = tag_q;

endmodule

// File: rtl/rename_regfile.sv
// rename_regfile
//   Architectural register file with renaming for the Tomasulo core. Each register holds a
//   value, a busy bit and the ROB tag of its newest in-flight producer.
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-high; overrides issue, commit and flush
//   bus   : rename_regfile_if.slave -- NUM_RD combinational read ports, rename request,
//           ROB commit and flush
//   Build option: define COMMIT_BYPASS_EN to forward a tag-matching commit onto the read
//   ports in the same cycle (value = cmt_value, busy = 0).
//   Indices >= NUM_REGS ignore writes and read as zero.
module rename_regfile
   import rename_regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = REG_DATA_W,
   parameter int unsigned TAG_WIDTH  = ROB_TAG_W,
   parameter int unsigned NUM_REGS   = NUM_ARCH_REGS,
   parameter int unsigned NUM_RD     = NUM_RD_PORTS
) (
   input  logic            clk,
   input  logic            reset,
   rename_regfile_if.slave bus
);

   localparam int unsigned IDX_W = idx_width(NUM_REGS);

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_value;
   logic [NUM_REGS-1:0]                 reg_busy;
   logic [NUM_REGS-1:0][TAG_WIDTH-1:0]  reg_tag;
   logic [NUM_REGS-1:0]                 iss_hit;
   logic [NUM_REGS-1:0]                 cmt_hit;

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      // Out-of-range indices decode to no entry, so those writes vanish.
      assign iss_hit[r] = bus.iss_valid && (bus.iss_idx == IDX_W'(r));
      assign cmt_hit[r] = bus.cmt_valid && (bus.cmt_idx == IDX_W'(r));

      rename_regfile_entry #(
         .DATA_WIDTH (DATA_WIDTH),
         .TAG_WIDTH  (TAG_WIDTH)
      ) u_entry (
         .clk       (clk),
         .reset     (reset),
         .iss_hit   (iss_hit[r]),
         .iss_tag   (bus.iss_tag),
         .cmt_hit   (cmt_hit[r]),
         .cmt_tag   (bus.cmt_tag),
         .cmt_value (bus.cmt_value),
         .flush     (bus.flush),
         .value     (reg_value[r]),
         .busy      (reg_busy[r]),
         .tag       (reg_tag[r])
      );
   end

`ifdef COMMIT_BYPASS_EN
   // Commit that will clear busy this cycle; forwarded to matching read ports.
   logic cmt_match;

   always_comb begin
      cmt_match = 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         if (cmt_hit[r] && (reg_tag[r] == bus.cmt_tag)) begin
            cmt_match = 1'b1;
         end
      end
   end
`endif

   logic [IDX_W-1:0] rd_sel;

   always_comb begin
      bus.rd_value = '0;
      bus.rd_busy  = '0;
      bus.rd_tag   = '0;
      rd_sel       = '0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         rd_sel = bus.rd_idx[p*IDX_W +: IDX_W];
         if (32'(rd_sel) < NUM_REGS) begin
            bus.rd_value[p*DATA_WIDTH +: DATA_WIDTH] = reg_value[rd_sel];
            bus.rd_busy[p]                           = reg_busy[rd_sel];
            bus.rd_tag[p*TAG_WIDTH +: TAG_WIDTH]     = reg_tag[rd_sel];
`ifdef COMMIT_BYPASS_EN
            // A concurrent rename of the same register shows up next cycle.
            if (cmt_match && (rd_sel == bus.cmt_idx)) begin
               bus.rd_value[p*DATA_WIDTH +: DATA_WIDTH] = bus.cmt_value;
               bus.rd_busy[p]                           = 1'b0;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile
//   Directed scoreboard bench for rename_regfile at default parameters. The stimulus
//   process drives one cycle of inputs just after each rising edge and queues the expected
//   read-port contents; the monitor compares them on the falling edge.
module tb_rename_regfile;
   import rename_regfile_pkg::*;

   localparam int unsigned DW = REG_DATA_W;
   localparam int unsigned TW = ROB_TAG_W;
   localparam int unsigned IW = idx_width(NUM_ARCH_REGS);

   typedef struct {
      string       name;
      int unsigned port;
      regfile_t    exp;
      logic        chk_tag;
   } exp_t;

   logic clk;
   logic reset;
   logic chk_valid;
   int   checks;
   int   failures;
   exp_t sb[$];

   rename_regfile_if #(
      .DATA_WIDTH (DW),
      .TAG_WIDTH  (TW),
      .NUM_REGS   (NUM_ARCH_REGS),
      .NUM_RD     (NUM_RD_PORTS)
   ) bus ();

   rename_regfile #(
      .DATA_WIDTH (DW),
      .TAG_WIDTH  (TW),
      .NUM_REGS   (NUM_ARCH_REGS),
      .NUM_RD     (NUM_RD_PORTS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: compare every queued expectation against the live read ports.
   always @(negedge clk) begin
      if (chk_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: read strobe with no expected entry");
         end
         while (sb.size() > 0) begin
            exp_t     e;
            regfile_t act;
            logic     ok;
            e   = sb.pop_front();
            act = pack_regfile(bus.rd_busy[e.port], bus.rd_tag[e.port*TW +: TW],
                               bus.rd_value[e.port*DW +: DW]);
            ok  = (act.busy == e.exp.busy) && (act.data == e.exp.data) &&
                  (!e.chk_tag || (act.rob_entry == e.exp.rob_entry));
            checks++;
            if (!ok) begin
               failures++;
               $display("FAIL %s port%0d: got value=%h busy=%b tag=%0d, want value=%h busy=%b tag=%0d%s",
                        e.name, e.port, act.data, act.busy, act.rob_entry,
                        e.exp.data, e.exp.busy, e.exp.rob_entry, e.chk_tag ? "" : "(any)");
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
      bus.iss_valid = 1'b0;
      bus.iss_idx   = '0;
      bus.iss_tag   = '0;
      bus.cmt_valid = 1'b0;
      bus.cmt_idx   = '0;
      bus.cmt_tag   = '0;
      bus.cmt_value = '0;
      bus.flush     = 1'b0;
      bus.rd_idx    = '0;
      chk_valid     = 1'b0;
   endtask

   task automatic issue(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
      bus.iss_valid = 1'b1;
      bus.iss_idx   = idx;
      bus.iss_tag   = tag;
   endtask

   task automatic commit(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                         input logic [DW-1:0] value);
      bus.cmt_valid = 1'b1;
      bus.cmt_idx   = idx;
      bus.cmt_tag   = tag;
      bus.cmt_value = value;
   endtask

   task automatic expect_rd(input string name, input int unsigned port,
                            input logic [IW-1:0] idx, input logic [DW-1:0] value,
                            input logic busy, input logic [TW-1:0] tag, input logic chk_tag);
      exp_t e;
      bus.rd_idx[port*IW +: IW] = idx;
      e.name    = name;
      e.port    = port;
      e.exp     = pack_regfile(busy, tag, value);
      e.chk_tag = chk_tag;
      sb.push_back(e);
      chk_valid = 1'b1;
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      chk_valid     = 1'b0;
      reset         = 1'b1;
      bus.iss_valid = 1'b0;
      bus.iss_idx   = '0;
      bus.iss_tag   = '0;
      bus.cmt_valid = 1'b0;
      bus.cmt_idx   = '0;
      bus.cmt_tag   = '0;
      bus.cmt_value = '0;
      bus.flush     = 1'b0;
      bus.rd_idx    = '0;

      next_cycle();
      next_cycle();

      // 1: reset state, every register through all three ports
      for (int base = 0; base < 8; base += 3) begin
         next_cycle();
         reset = 1'b0;
         for (int p = 0; p < 3; p++) begin
            if (base + p < 8) begin
               expect_rd("reset_state", p, IW'(base + p), 16'h0000, 1'b0, 3'd0, 1'b1);
            end
         end
      end

      // 2: rename then matching commit
      next_cycle();
      issue(3'd3, 3'd5);
      next_cycle();
      expect_rd("r3_renamed", 0, 3'd3, 16'h0000, 1'b1, 3'd5, 1'b1);
      commit(3'd3, 3'd5, 16'hBEEF);
`ifdef COMMIT_BYPASS_EN
      expect_rd("r3_bypass", 1, 3'd3, 16'hBEEF, 1'b0, 3'd5, 1'b1);
`else
      expect_rd("r3_no_bypass", 1, 3'd3, 16'h0000, 1'b1, 3'd5, 1'b1);
`endif
      next_cycle();
      expect_rd("r3_committed", 0, 3'd3, 16'hBEEF, 1'b0, 3'd5, 1'b1);

      // 3: stale commit keeps younger producer
      next_cycle();
      issue(3'd2, 3'd1);
      next_cycle();
      issue(3'd2, 3'd4);
      next_cycle();
      commit(3'd2, 3'd1, 16'h0011);
      expect_rd("r2_stale_cmt_cycle", 2, 3'd2, 16'h0000, 1'b1, 3'd4, 1'b1);
      next_cycle();
      expect_rd("r2_stale_cmt", 0, 3'd2, 16'h0011, 1'b1, 3'd4, 1'b1);

      // 4: issue and matching commit, same register, same cycle
      next_cycle();
      issue(3'd6, 3'd6);
      next_cycle();
      issue(3'd6, 3'd2);
      commit(3'd6, 3'd6, 16'h1234);
      next_cycle();
      expect_rd("r6_issue_wins", 1, 3'd6, 16'h1234, 1'b1, 3'd2, 1'b1);
      expect_rd("r3_untouched", 2, 3'd3, 16'hBEEF, 1'b0, 3'd5, 1'b1);

      // 5: flush drops a concurrent issue, keeps a concurrent commit
      next_cycle();
      issue(3'd1, 3'd1);
      next_cycle();
      issue(3'd4, 3'd2);
      next_cycle();
      issue(3'd7, 3'd3);
      next_cycle();
      bus.flush = 1'b1;
      issue(3'd5, 3'd3);
      commit(3'd4, 3'd2, 16'h00AA);
      next_cycle();
      expect_rd("flush_r1", 0, 3'd1, 16'h0000, 1'b0, 3'd0, 1'b0);
      expect_rd("flush_r4", 1, 3'd4, 16'h00AA, 1'b0, 3'd0, 1'b0);
      expect_rd("flush_r7", 2, 3'd7, 16'h0000, 1'b0, 3'd0, 1'b0);
      next_cycle();
      expect_rd("flush_r5_unrenamed", 0, 3'd5, 16'h0000, 1'b0, 3'd0, 1'b1);
      expect_rd("flush_r6", 1, 3'd6, 16'h1234, 1'b0, 3'd0, 1'b0);
      expect_rd("flush_r2", 2, 3'd2, 16'h0011, 1'b0, 3'd0, 1'b0);

      // 6: commit visibility on aliased read ports
      next_cycle();
      issue(3'd0, 3'd7);
      next_cycle();
      commit(3'd0, 3'd7, 16'h5A5A);
      for (int p = 0; p < 3; p++) begin
`ifdef COMMIT_BYPASS_EN
         expect_rd("r0_bypass_alias", p, 3'd0, 16'h5A5A, 1'b0, 3'd7, 1'b1);
`else
         expect_rd("r0_no_bypass_alias", p, 3'd0, 16'h0000, 1'b1, 3'd7, 1'b1);
`endif
      end
      next_cycle();
      expect_rd("r0_committed", 0, 3'd0, 16'h5A5A, 1'b0, 3'd7, 1'b1);

      // Issue and commit to different registers in the same cycle
      next_cycle();
      issue(3'd2, 3'd4);
      next_cycle();
      issue(3'd1, 3'd5);
      commit(3'd2, 3'd4, 16'h2222);
`ifdef COMMIT_BYPASS_EN
      expect_rd("r2_diff_bypass", 0, 3'd2, 16'h2222, 1'b0, 3'd4, 1'b1);
`else
      expect_rd("r2_diff_no_bypass", 0, 3'd2, 16'h0011, 1'b1, 3'd4, 1'b1);
`endif
      next_cycle();
      expect_rd("r1_diff_issue", 0, 3'd1, 16'h0000, 1'b1, 3'd5, 1'b1);
      expect_rd("r2_diff_commit", 1, 3'd2, 16'h2222, 1'b0, 3'd4, 1'b1);

      // Reset mid-stream discards concurrent issue and commit
      next_cycle();
      reset = 1'b1;
      issue(3'd3, 3'd1);
      commit(3'd5, 3'd0, 16'hFFFF);
      next_cycle();
      reset = 1'b0;
      expect_rd("rst_r3", 0, 3'd3, 16'h0000, 1'b0, 3'd0, 1'b1);
      expect_rd("rst_r5", 1, 3'd5, 16'h0000, 1'b0, 3'd0, 1'b1);
      expect_rd("rst_r0", 2, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);

      next_cycle();
      next_cycle();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
